// File: rtl/uart_th_commander.sv
// uart_th_commander: host-side initiator for the threshold-tuning UART exchange.
// One accepted command sends the mode letter and the direction letter, checks that
// each comes back as an echo, then collects the updated threshold: two bytes
// MSB-first for solar ('A'), one signed byte for every other mode.
module uart_th_commander #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_mode,
  input  logic        cmd_dir,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_idle,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [15:0] rsp_value,
  output logic [1:0]  rsp_err
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_MODE,
    WAIT_MODE_ECHO,
    SEND_DIR,
    WAIT_DIR_ECHO,
    WAIT_MSB,
    WAIT_LSB,
    DONE
  } state_t;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  ERR_OK       = 2'd0;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0]  ERR_ECHO     = 2'd2;
  localparam logic [1:0]  ERR_MODE     = 2'd3;
  localparam logic [3:0]  MAX_MODE     = 4'd8;
  localparam logic [3:0]  SOLAR_MODE   = 4'd0;
  localparam logic [7:0]  BYTE_A       = 8'h41;
  localparam logic [7:0]  BYTE_INC     = 8'h77;
  localparam logic [7:0]  BYTE_DEC     = 8'h73;

  state_t      state;
  state_t      next_state;
  logic [3:0]  mode_q;
  logic        dir_q;
  logic [7:0]  msb_q;
  logic [31:0] wait_cnt;

  logic        in_wait;
  logic        timed_out;
  logic        load_cmd;
  logic        do_send;
  logic [7:0]  send_byte;
  logic        capture_msb;
  logic        finish;
  logic [15:0] fin_value;
  logic [1:0]  fin_err;

  assign cmd_ready = (state == IDLE);
  assign in_wait   = (state == WAIT_MODE_ECHO) || (state == WAIT_DIR_ECHO) ||
                     (state == WAIT_MSB) || (state == WAIT_LSB);
  assign timed_out = in_wait && (wait_cnt == TIMEOUT_LAST);

  // State register; reset drops any exchange in flight without responding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-cycle actions; a received byte takes priority over a timeout.
  always_comb begin
    next_state  = state;
    load_cmd    = 1'b0;
    do_send     = 1'b0;
    send_byte   = 8'h00;
    capture_msb = 1'b0;
    finish      = 1'b0;
    fin_value   = 16'h0000;
    fin_err     = ERR_OK;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          load_cmd = 1'b1;
          if (cmd_mode > MAX_MODE) begin
            finish     = 1'b1;
            fin_err    = ERR_MODE;
            next_state = DONE;
          end else begin
            next_state = SEND_MODE;
          end
        end
      end
      SEND_MODE: begin
        if (tx_idle) begin
          do_send    = 1'b1;
          send_byte  = BYTE_A + {4'h0, mode_q};
          next_state = WAIT_MODE_ECHO;
        end
      end
      WAIT_MODE_ECHO: begin
        if (rx_valid) begin
          if (rx_data == tx_data) begin
            next_state = SEND_DIR;
          end else begin
            finish     = 1'b1;
            fin_err    = ERR_ECHO;
            next_state = DONE;
          end
        end else if (timed_out) begin
          finish     = 1'b1;
          fin_err    = ERR_TIMEOUT;
          next_state = DONE;
        end
      end
      SEND_DIR: begin
        if (tx_idle) begin
          do_send    = 1'b1;
          send_byte  = dir_q ? BYTE_INC : BYTE_DEC;
          next_state = WAIT_DIR_ECHO;
        end
      end
      WAIT_DIR_ECHO: begin
        if (rx_valid) begin
          if (rx_data == tx_data) begin
            next_state = WAIT_MSB;
          end else begin
            finish     = 1'b1;
            fin_err    = ERR_ECHO;
            next_state = DONE;
          end
        end else if (timed_out) begin
          finish     = 1'b1;
          fin_err    = ERR_TIMEOUT;
          next_state = DONE;
        end
      end
      WAIT_MSB: begin
        if (rx_valid) begin
          if (mode_q == SOLAR_MODE) begin
            capture_msb = 1'b1;
            next_state  = WAIT_LSB;
          end else begin
            finish     = 1'b1;
            fin_value  = {{8{rx_data[7]}}, rx_data};
            next_state = DONE;
          end
        end else if (timed_out) begin
          finish     = 1'b1;
          fin_err    = ERR_TIMEOUT;
          next_state = DONE;
        end
      end
      WAIT_LSB: begin
        if (rx_valid) begin
          finish     = 1'b1;
          fin_value  = {msb_q, rx_data};
          next_state = DONE;
        end else if (timed_out) begin
          finish     = 1'b1;
          fin_err    = ERR_TIMEOUT;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Registered outputs, latched command, captured MSB and the per-wait timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_value <= 16'h0000;
      rsp_err   <= ERR_OK;
      mode_q    <= 4'h0;
      dir_q     <= 1'b0;
      msb_q     <= 8'h00;
      wait_cnt  <= 32'h0;
    end else begin
      tx_start  <= do_send;
      rsp_valid <= finish;
      if (do_send) begin
        tx_data <= send_byte;
      end
      if (finish) begin
        rsp_value <= fin_value;
        rsp_err   <= fin_err;
      end
      if (load_cmd) begin
        mode_q <= cmd_mode;
        dir_q  <= cmd_dir;
      end
      if (capture_msb) begin
        msb_q <= rx_data;
      end
      if (next_state != state) begin
        wait_cnt <= 32'h0;
      end else if (in_wait) begin
        wait_cnt <= wait_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_th_commander.sv
// tb_uart_th_commander: plays the remote UART end for uart_th_commander, scoreboards
// transmitted bytes and responses against a protocol-level reference model.
module tb_uart_th_commander;

  localparam int TMO = 16;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_mode  = 4'h0;
  logic        cmd_dir   = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_idle   = 1'b1;
  logic [7:0]  rx_data   = 8'h00;
  logic        rx_valid  = 1'b0;
  logic        rsp_valid;
  logic [15:0] rsp_value;
  logic [1:0]  rsp_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] value;
    logic [1:0]  err;
  } rsp_t;

  // fault: 0 none, 1 bad mode echo, 2 bad dir echo, 3 silent mode echo,
  //        4 silent dir echo, 5 silent data byte, 6 silent solar LSB
  typedef struct {
    logic [3:0] mode;
    logic       dir;
    int         fault;
    logic [7:0] msb;
    logic [7:0] lsb;
    logic [7:0] echo_xor;
    bit         stall;
    bit         junk;
    bit         abort;
  } scen_t;

  rsp_t       rsp_q[$];
  logic [7:0] tx_q[$];
  bit         hold_busy     = 1'b0;
  int         busy_left     = 0;
  logic       prev_tx_start = 1'b0;
  logic [7:0] exp_tx;
  rsp_t       exp_rsp;

  always #5 clk = ~clk;

  uart_th_commander #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_dir   (cmd_dir),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_idle   (tx_idle),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rsp_valid (rsp_valid),
    .rsp_value (rsp_value),
    .rsp_err   (rsp_err)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Protocol-level model: which bytes go out and what the response must be.
  function automatic void model(input scen_t s, output logic [15:0] value, output logic [1:0] err,
                                output int ntx, output logic [7:0] mode_byte,
                                output logic [7:0] dir_byte);
    string letters = "ABCDEFGHI";
    string dirs    = "sw";
    int    signed_val;
    value     = 16'h0000;
    err       = 2'd0;
    ntx       = 2;
    mode_byte = 8'h00;
    dir_byte  = 8'h00;
    if (s.mode > 4'd8) begin
      err = 2'd3;
      ntx = 0;
      return;
    end
    mode_byte = letters[int'(s.mode)];
    dir_byte  = dirs[s.dir ? 1 : 0];
    case (s.fault)
      1: begin ntx = 1; err = 2'd2; end
      3: begin ntx = 1; err = 2'd1; end
      2: err = 2'd2;
      4, 5, 6: err = 2'd1;
      default: begin
        if (s.mode == 4'd0) begin
          value = 16'(int'(s.msb) * 256 + int'(s.lsb));
        end else begin
          signed_val = (s.msb >= 8'd128) ? int'(s.msb) - 256 : int'(s.msb);
          value      = 16'(signed_val);
        end
      end
    endcase
  endfunction

  function automatic scen_t mk(input int mode, input int dir, input int fault, input int msb,
                               input int lsb, input int xr, input int stall, input int junk,
                               input int abort);
    scen_t s;
    s.mode     = 4'(mode);
    s.dir      = 1'(dir);
    s.fault    = fault;
    s.msb      = 8'(msb);
    s.lsb      = 8'(lsb);
    s.echo_xor = 8'(xr);
    s.stall    = (stall != 0);
    s.junk     = (junk != 0);
    s.abort    = (abort != 0);
    return s;
  endfunction

  // Remote transmitter model: busy for a few cycles after each start pulse, or held busy.
  always @(negedge clk) begin
    if (rst) begin
      busy_left = 0;
    end else if (tx_start) begin
      busy_left = int'($urandom_range(1, 6));
    end else if (busy_left > 0) begin
      busy_left--;
    end
    tx_idle = (busy_left == 0) && !hold_busy;
  end

  // Transmit monitor: every start pulse is a single cycle and carries the next expected byte.
  always @(negedge clk) begin
    if (!rst && tx_start) begin
      checkOutput("tx_pulse_width", int'(prev_tx_start), 0);
      checkOutput("tx_expected_pending", int'(tx_q.size() > 0), 1);
      if (tx_q.size() > 0) begin
        exp_tx = tx_q.pop_front();
        checkOutput("tx_data", int'(tx_data), int'(exp_tx));
      end
    end
    prev_tx_start = tx_start;
  end

  // Response monitor: every response pulse is matched against the next expected response.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      checkOutput("rsp_expected_pending", int'(rsp_q.size() > 0), 1);
      if (rsp_q.size() > 0) begin
        exp_rsp = rsp_q.pop_front();
        checkOutput("rsp_err", int'(rsp_err), int'(exp_rsp.err));
        if (exp_rsp.err != 2'd2) begin
          checkOutput("rsp_value", int'(rsp_value), int'(exp_rsp.value));
        end
      end
    end
  end

  task automatic wait_tx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("tx_start_seen", int'(ok), 1);
  endtask

  task automatic wait_rsp(input string name, input int expected_cycles);
    int cyc = 0;
    while (!rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput(name, cyc, expected_cycles);
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    repeat ($urandom_range(0, 12)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic applyStimulus(input scen_t s);
    logic [15:0] ev;
    logic [1:0]  ee;
    int          ntx;
    logic [7:0]  b0;
    logic [7:0]  b1;
    bit          ok;
    bit          accepted;
    model(s, ev, ee, ntx, b0, b1);
    if (!s.abort) rsp_q.push_back('{ev, ee});
    if (ntx > 0) tx_q.push_back(b0);
    if (ntx > 1) tx_q.push_back(b1);
    hold_busy = s.stall;
    @(negedge clk);
    cmd_mode  = s.mode;
    cmd_dir   = s.dir;
    cmd_valid = 1'b1;
    accepted  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("cmd_accept", int'(accepted), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_mode  = 4'($urandom);
    cmd_dir   = 1'($urandom);
    if (s.mode > 4'd8) begin
      wait_rsp("badmode_latency", 0);
      repeat (3) @(negedge clk);
      return;
    end
    if (s.stall) begin
      bit saw = 1'b0;
      repeat (100) begin
        if (tx_start) saw = 1'b1;
        @(negedge clk);
      end
      checkOutput("stall_no_tx", int'(saw), 0);
      hold_busy = 1'b0;
    end
    wait_tx(ok);
    if (!ok) return;
    if (s.fault == 3) begin
      wait_rsp("timeout_mode_echo", TMO);
      return;
    end
    repeat ($urandom_range(0, 12)) @(negedge clk);
    rx_data  = (s.fault == 1) ? (b0 ^ s.echo_xor) : b0;
    rx_valid = 1'b1;
    @(negedge clk);
    if (s.fault == 1) begin
      rx_valid = 1'b0;
      wait_rsp("echo_mode_latency", 0);
      return;
    end
    if (s.junk) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    wait_tx(ok);
    if (!ok) return;
    if (s.fault == 4) begin
      wait_rsp("timeout_dir_echo", TMO);
      return;
    end
    pulse_rx((s.fault == 2) ? (b1 ^ s.echo_xor) : b1);
    if (s.fault == 2) begin
      wait_rsp("echo_dir_latency", 0);
      return;
    end
    if (s.abort) begin
      repeat ($urandom_range(0, 10)) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("abort_cmd_ready", int'(cmd_ready), 1);
      checkOutput("abort_rsp_valid", int'(rsp_valid), 0);
      checkOutput("abort_tx_start", int'(tx_start), 0);
      checkOutput("abort_tx_data", int'(tx_data), 0);
      checkOutput("abort_rsp_value", int'(rsp_value), 0);
      rst = 1'b0;
      repeat (TMO + 10) @(negedge clk);
      return;
    end
    if (s.fault == 5) begin
      wait_rsp("timeout_msb", TMO);
      return;
    end
    pulse_rx(s.msb);
    if (s.mode != 4'd0) begin
      wait_rsp("rsp_latency", 0);
      return;
    end
    if (s.fault == 6) begin
      wait_rsp("timeout_lsb", TMO);
      return;
    end
    pulse_rx(s.lsb);
    wait_rsp("rsp_latency", 0);
  endtask

  // Safety net so the run always ends even if the design stops responding.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed exchanges, then randomized commands.
  initial begin
    scen_t s;
    int    r;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_cmd_ready", int'(cmd_ready), 1);
    checkOutput("reset_tx_start", int'(tx_start), 0);
    checkOutput("reset_tx_data", int'(tx_data), 0);
    checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
    checkOutput("reset_rsp_value", int'(rsp_value), 0);
    checkOutput("reset_rsp_err", int'(rsp_err), 0);
    rst = 1'b0;

    applyStimulus(mk(3, 1, 0, 8'h24, 0, 1, 0, 0, 0));
    applyStimulus(mk(0, 0, 0, 8'h09, 8'hC4, 1, 0, 0, 0));
    applyStimulus(mk(2, 0, 0, 8'hF4, 0, 1, 0, 0, 0));
    applyStimulus(mk(5, 1, 0, 8'h80, 0, 1, 1, 0, 0));
    applyStimulus(mk(0, 1, 3, 0, 0, 1, 0, 0, 0));
    applyStimulus(mk(3, 1, 1, 0, 0, 1, 0, 0, 0));
    applyStimulus(mk(9, 0, 0, 0, 0, 1, 0, 0, 0));
    applyStimulus(mk(8, 1, 0, 8'h7F, 0, 1, 0, 1, 0));
    applyStimulus(mk(4, 0, 0, 8'h10, 0, 1, 0, 0, 1));
    applyStimulus(mk(4, 0, 0, 8'h10, 0, 1, 0, 0, 0));
    applyStimulus(mk(0, 0, 6, 8'h12, 0, 1, 0, 0, 0));

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) s.mode = 4'($urandom_range(9, 15));
      else                           s.mode = 4'($urandom_range(0, 8));
      s.dir = 1'($urandom);
      r = int'($urandom_range(0, 9));
      if (r <= 5)      s.fault = 0;
      else if (r == 6) s.fault = 1;
      else if (r == 7) s.fault = 2;
      else if (r == 8) s.fault = int'($urandom_range(3, 5));
      else             s.fault = 6;
      if (s.fault == 6 && s.mode != 4'd0) s.fault = 5;
      s.msb      = 8'($urandom);
      s.lsb      = 8'($urandom);
      s.echo_xor = 8'($urandom_range(1, 255));
      s.stall    = 1'b0;
      s.junk     = 1'($urandom);
      s.abort    = 1'b0;
      applyStimulus(s);
    end

    repeat (5) @(negedge clk);
    checkOutput("rsp_queue_drained", rsp_q.size(), 0);
    checkOutput("tx_queue_drained", tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
